// File: rtl/temp_sample_averager.sv
// temp_sample_averager: die-temperature conditioning stage.
// Offset removal, clamping, windowed mean/min/max, one-entry output buffer.
module temp_sample_averager #(
   parameter int CHANNEL = 17,
   parameter int OFFSET  = 3431,
   parameter int LOG2_N  = 4
) (
   input  logic        clock_in,
   input  logic        reset_n,
   input  logic        sample_tick,
   input  logic        in_valid,
   input  logic [4:0]  in_channel,
   input  logic [11:0] in_data,
   input  logic        clear,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [8:0]  out_data,
   output logic [8:0]  out_min,
   output logic [8:0]  out_max,
   output logic [7:0]  drop_count
);

   localparam int AW = 9 + LOG2_N;

   logic [AW-1:0]     acc;
   logic [LOG2_N-1:0] cnt;
   logic [8:0]        wmin;
   logic [8:0]        wmax;

   logic              accept;
   logic              first;
   logic              last;
   logic              complete;
   logic              xfer;
   logic              load;
   logic [11:0]       diff;
   logic [8:0]        s;
   logic [AW-1:0]     acc_sum;
   logic [8:0]        min_n;
   logic [8:0]        max_n;

   // Qualify the sample and derive the window-position flags.
   always_comb begin
      accept   = sample_tick && in_valid &&
                 (in_channel == 5'(CHANNEL)) && !clear;
      first    = (cnt == '0);
      last     = (cnt == '1);
      complete = accept && last;
      xfer     = out_valid && out_ready;
      load     = complete && (!out_valid || out_ready);
   end

   // Remove the offset and clamp to the 9-bit display range.
   always_comb begin
      diff = in_data - 12'(OFFSET);
      if (in_data < 12'(OFFSET)) begin
         s = 9'd0;
      end else if (diff > 12'd511) begin
         s = 9'd511;
      end else begin
         s = diff[8:0];
      end
   end

   // Running sum and extremes including the current sample.
   always_comb begin
      acc_sum = (first ? '0 : acc) + AW'(s);
      min_n   = s;
      max_n   = s;
      if (!first) begin
         if (wmin < s) min_n = wmin;
         if (wmax > s) max_n = wmax;
      end
   end

   // Window accumulator and sample counter; counter wraps after N samples.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         acc  <= '0;
         cnt  <= '0;
         wmin <= '0;
         wmax <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (accept) begin
         acc  <= acc_sum;
         wmin <= min_n;
         wmax <= max_n;
         cnt  <= cnt + 1'b1;
      end
   end

   // One-entry result buffer; a full, stalled buffer keeps its old result.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_min   <= '0;
         out_max   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= acc_sum[AW-1:LOG2_N];
         out_min   <= min_n;
         out_max   <= max_n;
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating count of results discarded under backpressure.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= '0;
      end else if (clear) begin
         drop_count <= '0;
      end else if (complete && out_valid && !out_ready &&
                   (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_temp_sample_averager.sv
// tb_temp_sample_averager: self-checking bench for temp_sample_averager.
// Directed scenarios plus random traffic against a queue-based model.
module tb_temp_sample_averager;

   logic        clock_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_tick = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  in_channel = '0;
   logic [11:0] in_data = '0;
   logic        clear = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [8:0]  out_data;
   logic [8:0]  out_min;
   logic [8:0]  out_max;
   logic [7:0]  drop_count;

   int errors = 0;
   int checks = 0;

   localparam int N = 16;

   // reference model state
   int m_win[$];
   bit m_valid;
   int m_data, m_min, m_max, m_drop;

   temp_sample_averager dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .sample_tick(sample_tick),
      .in_valid   (in_valid),
      .in_channel (in_channel),
      .in_data    (in_data),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_min    (out_min),
      .out_max    (out_max),
      .drop_count (drop_count)
   );

   always #5 clock_in = ~clock_in;

   function automatic int cond(input int d);
      int v;
      v = d - 3431;
      if (v < 0) v = 0;
      if (v > 511) v = 511;
      return v;
   endfunction

   task automatic model_reset();
      m_win.delete();
      m_valid = 0;
      m_data = 0;
      m_min = 0;
      m_max = 0;
      m_drop = 0;
   endtask

   task automatic model_apply(input bit tk, input bit vl, input int ch,
                              input int d, input bit clr, input bit rdy);
      bit done;
      int sum, mn, mx;
      done = 0;
      if (clr) begin
         m_win.delete();
         m_drop = 0;
      end
      if (tk && vl && ch == 17 && !clr) begin
         m_win.push_back(cond(d));
         if (m_win.size() == N) begin
            sum = 0;
            mn = 511;
            mx = 0;
            foreach (m_win[i]) begin
               sum += m_win[i];
               if (m_win[i] < mn) mn = m_win[i];
               if (m_win[i] > mx) mx = m_win[i];
            end
            m_win.delete();
            done = 1;
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_valid = 1;
            m_data = sum / N;
            m_min = mn;
            m_max = mx;
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic step(input bit tk, input bit vl, input int ch,
                       input int d, input bit clr, input bit rdy);
      sample_tick = tk;
      in_valid = vl;
      in_channel = 5'(ch);
      in_data = 12'(d);
      clear = clr;
      out_ready = rdy;
      model_apply(tk, vl, ch, d, clr, rdy);
      @(posedge clock_in);
      #1;
   endtask

   task automatic sample(input int d, input bit rdy);
      step(1, 1, 17, d, 0, rdy);
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 0, 0, 0, rdy);
   endtask

   task automatic do_reset();
      @(posedge clock_in);
      #2;
      reset_n = 1'b0;
      model_reset();
      #2;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %0b want 0", out_valid);
      end
      checks++;
      if ({out_data, out_min, out_max} !== 27'd0) begin
         errors++;
         $display("FAIL reset_data got %0d/%0d/%0d want 0/0/0",
                  out_data, out_min, out_max);
      end
      checks++;
      if (drop_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_drop got %0d want 0", drop_count);
      end
      @(posedge clock_in);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 15; i++) sample(3441, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early got valid=%0b want 0", out_valid);
      end
      sample(3441, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd10 ||
          out_min !== 9'd10 || out_max !== 9'd10) begin
         errors++;
         $display("FAIL basic got v=%0b %0d/%0d/%0d want 1 10/10/10",
                  out_valid, out_data, out_min, out_max);
      end
      idle(1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain got valid=%0b want 0", out_valid);
      end
   endtask

   task automatic test_filter();
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 17, 3000, 0, 0);
         step(1, 1, 5, 4095, 0, 0);
         step(1, 0, 17, 3431, 0, 0);
         sample(3500, 0);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd69 ||
          out_min !== 9'd69 || out_max !== 9'd69) begin
         errors++;
         $display("FAIL filter got v=%0b %0d/%0d/%0d want 1 69/69/69",
                  out_valid, out_data, out_min, out_max);
      end
      idle(1);
   endtask

   task automatic test_clamp();
      for (int i = 0; i < 8; i++) sample(3000, 0);
      for (int i = 0; i < 8; i++) sample(4095, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd255 ||
          out_min !== 9'd0 || out_max !== 9'd511) begin
         errors++;
         $display("FAIL clamp got v=%0b %0d/%0d/%0d want 1 255/0/511",
                  out_valid, out_data, out_min, out_max);
      end
      idle(1);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 16; i++) sample(3451, 0);
      for (int i = 0; i < 16; i++) sample(3461, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd20 ||
          drop_count !== 8'd1) begin
         errors++;
         $display("FAIL bp_hold got v=%0b d=%0d drop=%0d want 1 20 1",
                  out_valid, out_data, drop_count);
      end
      idle(1);
      checks++;
      if (out_valid !== 1'b0 || drop_count !== 8'd1) begin
         errors++;
         $display("FAIL bp_release got v=%0b drop=%0d want 0 1",
                  out_valid, drop_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) sample(3451, 0);
      for (int i = 0; i < 15; i++) sample(3461, 0);
      sample(3461, 1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd30 ||
          drop_count !== 8'd1) begin
         errors++;
         $display("FAIL b2b got v=%0b d=%0d drop=%0d want 1 30 1",
                  out_valid, out_data, drop_count);
      end
      idle(1);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 8; i++) sample(4000, 0);
      step(1, 1, 17, 4000, 1, 0);
      checks++;
      if (drop_count !== 8'd0) begin
         errors++;
         $display("FAIL clear_drop got %0d want 0", drop_count);
      end
      for (int i = 0; i < 15; i++) sample(3451, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_early got valid=%0b want 0", out_valid);
      end
      sample(3451, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd20 ||
          out_min !== 9'd20 || out_max !== 9'd20) begin
         errors++;
         $display("FAIL clear got v=%0b %0d/%0d/%0d want 1 20/20/20",
                  out_valid, out_data, out_min, out_max);
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 8; i++) sample(4000, 0);
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || {out_data, out_min, out_max} !== 27'd0 ||
          drop_count !== 8'd0) begin
         errors++;
         $display("FAIL rmid_zero got v=%0b %0d/%0d/%0d drop=%0d want 0",
                  out_valid, out_data, out_min, out_max, drop_count);
      end
      @(posedge clock_in);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 15; i++) sample(3461, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_early got valid=%0b want 0", out_valid);
      end
      sample(3461, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'd30 ||
          out_min !== 9'd30 || out_max !== 9'd30) begin
         errors++;
         $display("FAIL rmid got v=%0b %0d/%0d/%0d want 1 30/30/30",
                  out_valid, out_data, out_min, out_max);
      end
      idle(1);
   endtask

   task automatic test_random();
      bit tk, vl, clr, rdy;
      int ch, d;
      for (int i = 0; i < 1500; i++) begin
         tk = ($urandom_range(0, 9) != 0);
         vl = ($urandom_range(0, 9) != 0);
         ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : 17;
         d = int'($urandom_range(3350, 4095));
         if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 4095));
         clr = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 3) == 0);
         step(tk, vl, ch, d, clr, rdy);
         checks++;
         if (out_valid !== m_valid || drop_count !== 8'(m_drop)) begin
            errors++;
            $display("FAIL rand_ctl cyc %0d got v=%0b drop=%0d want %0b %0d",
                     i, out_valid, drop_count, m_valid, m_drop);
         end
         if (m_valid) begin
            checks++;
            if (out_data !== 9'(m_data) || out_min !== 9'(m_min) ||
                out_max !== 9'(m_max)) begin
               errors++;
               $display("FAIL rand_data cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                        i, out_data, out_min, out_max, m_data, m_min, m_max);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_clamp();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
